// File: rtl/matrix_mult_engine.sv
// N x N unsigned integer matrix multiply engine with optional accumulate into the held result.
// Operands A then B arrive over valid/ready; C is produced one element per cycle, then presented on valid/ready.
module matrix_mult_engine #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N*N*W-1:0] dataInBus,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_mode,
  output logic [N*N*W-1:0] dataOut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int NE = N * N;
  localparam int MW = NE * W;
  localparam int IW = $clog2(NE + 1);
  localparam logic [IW-1:0] IDX_DONE = IW'(NE);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, OUTPUT} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, dout_q, dout_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            acc_q, acc_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  int              elem_idx;

  // Row-times-column dot product; every product and partial sum wraps modulo 2^W.
  function automatic logic [W-1:0] dot_elem(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                            input int row, input int col);
    logic [W-1:0] sum;
    sum = '0;
    for (int k = 0; k < N; k++) begin
      sum = sum + a[(row*N + k)*W +: W] * b[(k*N + col)*W +: W];
    end
    return sum;
  endfunction

  function automatic logic [W-1:0] acc_wrap(input logic [W-1:0] c_old, input logic [W-1:0] sum,
                                            input logic en);
    return en ? c_old + sum : sum;
  endfunction

  assign elem_idx = int'(idx_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    dout_d  = dout_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    case (state_q)
      LOAD_A: begin
        if (in_valid && in_ready_q) begin
          a_d     = dataInBus;
          acc_d   = acc_mode;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (in_valid && in_ready_q) begin
          b_d     = dataInBus;
          idx_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        // One extra cycle after the last element write snapshots the finished C into dataOut.
        if (idx_q != IDX_DONE) begin
          c_d[elem_idx*W +: W] = acc_wrap(c_q[elem_idx*W +: W],
                                          dot_elem(a_q, b_q, elem_idx / N, elem_idx % N), acc_q);
          idx_d = idx_q + 1'b1;
        end else begin
          dout_d  = c_q;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_valid_q && out_ready) state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
    in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
    out_valid_d = (state_d == OUTPUT);
    busy_d      = (state_d != LOAD_A);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD_A;
      c_q         <= '0;
      dout_q      <= '0;
      idx_q       <= '0;
      acc_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      dout_q      <= dout_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Operand registers are only meaningful after a fresh load, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign dataOut   = dout_q;

endmodule

// File: tb/tb_matrix_mult_engine.sv
// Bench for matrix_mult_engine: three instances (4x4/16, 2x2/8, 8x8/32) checked against a
// plain-arithmetic matrix model that tracks the accumulated C of each instance.
module tb_matrix_mult_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [2047:0] din;
  logic          iv, accm, ordy;
  int            sel;
  int            cn, cw;
  int            vectors, miscompares;
  logic [2047:0] mc [3];

  logic [255:0]  dout4;
  logic [31:0]   dout2;
  logic [2047:0] dout8;
  logic ir4, ir2, ir8, ov4, ov2, ov8, bz4, bz2, bz8;
  logic          ir_s, ov_s, bz_s;
  logic [2047:0] dout_s;

  matrix_mult_engine #(.N(4), .W(16)) u4 (
    .clk(clk), .reset(rst), .dataInBus(din[255:0]), .in_valid(iv && sel == 0), .in_ready(ir4),
    .acc_mode(accm), .dataOut(dout4), .out_valid(ov4), .out_ready(ordy && sel == 0), .busy(bz4));
  matrix_mult_engine #(.N(2), .W(8)) u2 (
    .clk(clk), .reset(rst), .dataInBus(din[31:0]), .in_valid(iv && sel == 1), .in_ready(ir2),
    .acc_mode(accm), .dataOut(dout2), .out_valid(ov2), .out_ready(ordy && sel == 1), .busy(bz2));
  matrix_mult_engine #(.N(8), .W(32)) u8 (
    .clk(clk), .reset(rst), .dataInBus(din), .in_valid(iv && sel == 2), .in_ready(ir8),
    .acc_mode(accm), .dataOut(dout8), .out_valid(ov8), .out_ready(ordy && sel == 2), .busy(bz8));

  assign ir_s   = (sel == 0) ? ir4 : (sel == 1) ? ir2 : ir8;
  assign ov_s   = (sel == 0) ? ov4 : (sel == 1) ? ov2 : ov8;
  assign bz_s   = (sel == 0) ? bz4 : (sel == 1) ? bz2 : bz8;
  assign dout_s = (sel == 0) ? 2048'(dout4) : (sel == 1) ? 2048'(dout2) : dout8;

  // ---------------- reference model ----------------
  function automatic longint unsigned el(input logic [2047:0] v, input int idx, input int w);
    longint unsigned mask = (64'd1 << w) - 1;
    return 64'(v >> (idx * w)) & mask;
  endfunction

  function automatic logic [2047:0] mm_ref(input int n, input int w, input logic [2047:0] a,
                                           input logic [2047:0] b, input logic [2047:0] c,
                                           input bit acc);
    logic [2047:0] r = '0;
    longint unsigned mask = (64'd1 << w) - 1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        longint unsigned s = 0;
        for (int k = 0; k < n; k++) s = (s + el(a, i*n + k, w) * el(b, k*n + j, w)) & mask;
        if (acc) s = (s + el(c, i*n + j, w)) & mask;
        r = r | (2048'(s) << ((i*n + j) * w));
      end
    return r;
  endfunction

  function automatic logic [2047:0] fill(input int n, input int w, input longint unsigned val);
    logic [2047:0] r = '0;
    for (int e = 0; e < n*n; e++) r = r | (2048'(val) << (e * w));
    return r;
  endfunction

  function automatic logic [2047:0] ident(input int n, input int w);
    logic [2047:0] r = '0;
    for (int i = 0; i < n; i++) r = r | (2048'(1) << ((i*n + i) * w));
    return r;
  endfunction

  function automatic logic [2047:0] rand_mat();
    logic [2047:0] r;
    for (int i = 0; i < 64; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_inst(input int s);
    sel = s;
    cn  = (s == 0) ? 4 : (s == 1) ? 2 : 8;
    cw  = (s == 0) ? 16 : (s == 1) ? 8 : 32;
  endtask

  task automatic put(input logic [2047:0] d, input bit am, output bit ok);
    int g = 0;
    din = d; accm = am; iv = 1'b1;
    while (!ir_s && g < 200) begin @(negedge clk); g++; end
    ok = ir_s;
    @(negedge clk);
    iv = 1'b0;
  endtask

  task automatic run_op(input logic [2047:0] a, input logic [2047:0] b, input bit am,
                        input bit hs, output int lat, output logic [2047:0] res);
    bit ok1, ok2;
    put(a, am, ok1);
    put(b, ~am, ok2);
    lat = 0;
    while (!ov_s && lat < 300) begin @(negedge clk); lat++; end
    if (!ov_s || !ok1 || !ok2) lat = -1;
    res = dout_s;
    if (hs) begin
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vectors += 4;
    if (ir4 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", ir4); end
    if (ov4 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", ov4); end
    if (bz4 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bz4); end
    if (dout4 !== '0) begin miscompares++; $display("FAIL reset_dataOut got %h want 0", dout4); end
    vectors += 2;
    if ({ir2, ov2, bz2} !== 3'b100) begin miscompares++; $display("FAIL reset_n2_ctrl got %b want 100", {ir2, ov2, bz2}); end
    if ({ir8, ov8, bz8} !== 3'b100) begin miscompares++; $display("FAIL reset_n8_ctrl got %b want 100", {ir8, ov8, bz8}); end
  endtask

  task automatic test_identity();
    logic [2047:0] a, b, exp, res;
    int lat;
    set_inst(0);
    a = ident(4, 16);
    b = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) b[(i*4 + j)*16 +: 16] = 16'(16'h0100 * i + j);
    exp = mm_ref(4, 16, a, b, mc[0], 1'b0); mc[0] = exp;
    run_op(a, b, 1'b0, 1'b1, lat, res);
    vectors += 3;
    if (res !== b) begin miscompares++; $display("FAIL identity_vs_B got %h want %h", res[255:0], b[255:0]); end
    if (res !== exp) begin miscompares++; $display("FAIL identity_model got %h want %h", res[255:0], exp[255:0]); end
    if (lat !== 17) begin miscompares++; $display("FAIL identity_latency got %0d want 17", lat); end
  endtask

  task automatic test_accumulate();
    logic [2047:0] a, b, exp, res;
    int lat;
    set_inst(0);
    a = fill(4, 16, 2); b = fill(4, 16, 3);
    exp = mm_ref(4, 16, a, b, mc[0], 1'b0); mc[0] = exp;
    run_op(a, b, 1'b0, 1'b1, lat, res);
    vectors += 2;
    if (res !== fill(4, 16, 'h18)) begin miscompares++; $display("FAIL acc_first got %h want all 0018", res[255:0]); end
    if (res !== exp) begin miscompares++; $display("FAIL acc_first_model got %h want %h", res[255:0], exp[255:0]); end
    exp = mm_ref(4, 16, a, b, mc[0], 1'b1); mc[0] = exp;
    run_op(a, b, 1'b1, 1'b1, lat, res);
    vectors += 2;
    if (res !== fill(4, 16, 'h30)) begin miscompares++; $display("FAIL acc_second got %h want all 0030", res[255:0]); end
    if (lat !== 17) begin miscompares++; $display("FAIL acc_latency got %0d want 17", lat); end
  endtask

  task automatic test_wrap();
    logic [2047:0] a, b, exp, res;
    int lat;
    set_inst(0);
    a = fill(4, 16, 'hFFFF); b = ident(4, 16);
    exp = mm_ref(4, 16, a, b, mc[0], 1'b0); mc[0] = exp;
    run_op(a, b, 1'b0, 1'b1, lat, res);
    vectors += 1;
    if (res !== a) begin miscompares++; $display("FAIL wrap_ffff got %h want %h", res[255:0], a[255:0]); end
    a = fill(4, 16, 'h8000); b = fill(4, 16, 2);
    exp = mm_ref(4, 16, a, b, mc[0], 1'b0); mc[0] = exp;
    run_op(a, b, 1'b0, 1'b1, lat, res);
    vectors += 2;
    if (res !== '0) begin miscompares++; $display("FAIL wrap_8000 got %h want 0", res[255:0]); end
    if (res !== exp) begin miscompares++; $display("FAIL wrap_model got %h want %h", res[255:0], exp[255:0]); end
  endtask

  task automatic test_back_pressure();
    logic [2047:0] a, b, exp, res;
    int lat;
    set_inst(0);
    a = rand_mat(); b = rand_mat();
    exp = mm_ref(4, 16, a, b, mc[0], 1'b0); mc[0] = exp;
    run_op(a, b, 1'b0, 1'b0, lat, res);
    vectors += 1;
    if (res !== exp) begin miscompares++; $display("FAIL bp_result got %h want %h", res[255:0], exp[255:0]); end
    for (int c = 0; c < 10; c++) begin
      iv = 1'($urandom_range(0, 1)); din = rand_mat(); accm = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors += 3;
      if (dout_s !== exp) begin miscompares++; $display("FAIL bp_stable cycle %0d got %h want %h", c, dout_s[255:0], exp[255:0]); end
      if (ir_s !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, ir_s); end
      if (ov_s !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid cycle %0d got %b want 1", c, ov_s); end
    end
    iv = 1'b1; ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0; iv = 1'b0;
    vectors += 4;
    if (ov_s !== 1'b0) begin miscompares++; $display("FAIL bp_release_out_valid got %b want 0", ov_s); end
    if (ir_s !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready got %b want 1", ir_s); end
    if (bz_s !== 1'b0) begin miscompares++; $display("FAIL bp_release_busy got %b want 0", bz_s); end
    if (dout_s !== exp) begin miscompares++; $display("FAIL bp_retain got %h want %h", dout_s[255:0], exp[255:0]); end
  endtask

  task automatic test_reset_mid_compute();
    logic [2047:0] exp, res;
    bit ok;
    int lat;
    set_inst(0);
    put(rand_mat(), 1'b0, ok);
    put(rand_mat(), 1'b0, ok);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mc[0] = '0; mc[1] = '0; mc[2] = '0;
    vectors += 4;
    if (ov_s !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got %b want 0", ov_s); end
    if (ir_s !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got %b want 1", ir_s); end
    if (bz_s !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", bz_s); end
    if (dout_s !== '0) begin miscompares++; $display("FAIL midrst_dataOut got %h want 0", dout_s[255:0]); end
    exp = mm_ref(4, 16, ident(4, 16), ident(4, 16), mc[0], 1'b1); mc[0] = exp;
    run_op(ident(4, 16), ident(4, 16), 1'b1, 1'b1, lat, res);
    vectors += 1;
    if (res !== ident(4, 16)) begin miscompares++; $display("FAIL midrst_acc_identity got %h want identity", res[255:0]); end
  endtask

  task automatic test_sweep(input int s);
    logic [2047:0] a, b, exp, res;
    bit am;
    int lat;
    set_inst(s);
    for (int t = 0; t < 200; t++) begin
      a = rand_mat(); b = rand_mat();
      if ($urandom_range(0, 7) == 0) a = fill(cn, cw, 64'hFFFF_FFFF);
      am = 1'($urandom_range(0, 1));
      exp = mm_ref(cn, cw, a, b, mc[s], am); mc[s] = exp;
      run_op(a, b, am, 1'b1, lat, res);
      vectors += 2;
      if (res !== exp) begin miscompares++; $display("FAIL sweep_n%0d op %0d got %h want %h", cn, t, res[255:0], exp[255:0]); end
      if (lat !== cn*cn + 1) begin miscompares++; $display("FAIL sweep_n%0d_latency op %0d got %0d want %0d", cn, t, lat, cn*cn + 1); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; din = '0; iv = 1'b0; accm = 1'b0; ordy = 1'b0;
    mc[0] = '0; mc[1] = '0; mc[2] = '0;
    set_inst(0);
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_identity();
    test_accumulate();
    test_wrap();
    test_back_pressure();
    test_reset_mid_compute();
    test_sweep(1);
    test_sweep(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
